// File: rtl/sgb_joy_link.sv
// Super Game Boy joypad link: serves player buttons, receives 128-bit command packets, decodes MLT_REQ.
// Optional multiplayer logic (MLT_REQ decode, player rotation, ID nibble) is built when SGB_MLT_EN is defined.
module sgb_joy_link #(
  parameter int NUM_PLAYERS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [1:0]               joy_p54,
  output logic [3:0]               joy_din,
  input  logic [8*NUM_PLAYERS-1:0] joystick,
  output logic [127:0]             pkt_data,
  output logic                     pkt_valid,
  output logic                     pkt_error,
  output logic                     pkt_busy,
  output logic [2:0]               mlt_players,
  output logic [1:0]               player_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WAIT_BIT,
    S_WAIT_HIGH,
    S_STOP
  } state_t;

  state_t       state;
  logic [1:0]   p54_q;
  logic [1:0]   p54_qq;
  logic [7:0]   bit_cnt;
  logic [127:0] shift_reg;
  logic [7:0]   sel_byte;
  logic [3:0]   id_nib;
  logic         pkt_ok;

  assign sel_byte = joystick[8*player_idx +: 8];
  assign pkt_ok   = clk_en && (state == S_STOP) && (p54_q == 2'b10);

  always_ff @(posedge clk) begin
    if (reset) begin
      p54_q   <= 2'b11;
      p54_qq  <= 2'b11;
      joy_din <= 4'hF;
    end else if (clk_en) begin
      p54_q  <= joy_p54;
      p54_qq <= p54_q;
      case (p54_q)
        2'b10:   joy_din <= ~sel_byte[3:0];
        2'b01:   joy_din <= ~sel_byte[7:4];
        2'b00:   joy_din <= ~(sel_byte[3:0] | sel_byte[7:4]);
        default: joy_din <= id_nib;
      endcase
    end
  end

  // Any 00 symbol inside a packet restarts reception from scratch without flagging an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pkt_busy  <= 1'b0;
      bit_cnt   <= 8'd0;
      shift_reg <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      if (clk_en) begin
        case (state)
          S_IDLE: begin
            if (p54_q == 2'b00) begin
              state     <= S_RST;
              pkt_busy  <= 1'b1;
              bit_cnt   <= 8'd0;
              shift_reg <= '0;
            end
          end
          S_RST: begin
            if (p54_q == 2'b11) state <= S_WAIT_BIT;
          end
          S_WAIT_BIT: begin
            case (p54_q)
              2'b10, 2'b01: begin
                shift_reg <= {p54_q[1] ^ 1'b1, shift_reg[127:1]};
                bit_cnt   <= bit_cnt + 8'd1;
                state     <= S_WAIT_HIGH;
              end
              2'b00: begin
                state     <= S_RST;
                bit_cnt   <= 8'd0;
                shift_reg <= '0;
              end
              default: state <= S_WAIT_BIT;
            endcase
          end
          S_WAIT_HIGH: begin
            if (p54_q == 2'b11) begin
              state <= (bit_cnt < 8'd128) ? S_WAIT_BIT : S_STOP;
            end else if (p54_q == 2'b00) begin
              state     <= S_RST;
              bit_cnt   <= 8'd0;
              shift_reg <= '0;
            end
          end
          S_STOP: begin
            case (p54_q)
              2'b10: begin
                pkt_valid <= 1'b1;
                pkt_data  <= shift_reg;
                pkt_busy  <= 1'b0;
                state     <= S_IDLE;
              end
              2'b01: begin
                pkt_error <= 1'b1;
                pkt_busy  <= 1'b0;
                state     <= S_IDLE;
              end
              2'b00: begin
                state     <= S_RST;
                bit_cnt   <= 8'd0;
                shift_reg <= '0;
              end
              default: state <= S_STOP;
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SGB_MLT_EN
  localparam logic [2:0] MAX_PLAYERS = 3'(NUM_PLAYERS);

  logic [2:0] mlt_req;

  always_comb begin
    mlt_req = 3'd1;
    case (shift_reg[9:8])
      2'd1:    mlt_req = 3'd2;
      2'd3:    mlt_req = 3'd4;
      default: mlt_req = 3'd1;
    endcase
    if (mlt_req > MAX_PLAYERS) mlt_req = MAX_PLAYERS;
  end

  assign id_nib = (mlt_players > 3'd1) ? (4'hF - {2'b00, player_idx}) : 4'hF;

  // MLT_REQ completion is checked last so it overrides a coincident rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      mlt_players <= 3'd1;
      player_idx  <= 2'd0;
    end else if (clk_en) begin
      if (p54_qq == 2'b01 && p54_q == 2'b11 && mlt_players > 3'd1 && !pkt_busy) begin
        player_idx <= ({1'b0, player_idx} == mlt_players - 3'd1) ? 2'd0 : player_idx + 2'd1;
      end
      if (pkt_ok && shift_reg[7:3] == 5'h11) begin
        mlt_players <= mlt_req;
        player_idx  <= 2'd0;
      end
    end
  end
`else
  assign mlt_players = 3'd1;
  assign player_idx  = 2'd0;
  assign id_nib      = 4'hF;
`endif

endmodule

// File: tb/tb_sgb_joy_link.sv
// Randomised scoreboard bench for sgb_joy_link; expectations come from a packet-level model of the link.
// Works for both builds: model follows SGB_MLT_EN the same way the design does.
module tb_sgb_joy_link;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b0;
  logic [1:0]    joy_p54 = 2'b11;
  logic [3:0]    joy_din;
  logic [8*NP-1:0] joystick = '0;
  logic [127:0]  pkt_data;
  logic          pkt_valid;
  logic          pkt_error;
  logic          pkt_busy;
  logic [2:0]    mlt_players;
  logic [1:0]    player_idx;

  sgb_joy_link #(.NUM_PLAYERS(NP)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .joy_p54     (joy_p54),
    .joy_din     (joy_din),
    .joystick    (joystick),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_error   (pkt_error),
    .pkt_busy    (pkt_busy),
    .mlt_players (mlt_players),
    .player_idx  (player_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           err;
    logic [127:0] data;
    logic [2:0]   mlt;
    logic [1:0]   idx;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [127:0] pkt_m;
  int           mlt_m;
  int           idx_m;
  bit           busy_m;
  logic [1:0]   last_sym;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] expNib(input logic [1:0] sel);
    logic [7:0] b;
    b = joystick[8*idx_m +: 8];
    case (sel)
      2'b10:   return ~b[3:0];
      2'b01:   return ~b[7:4];
      2'b00:   return ~(b[3:0] | b[7:4]);
      default: return (mlt_m > 1) ? 4'(15 - idx_m) : 4'hF;
    endcase
  endfunction

  function automatic int clampReq(input logic [1:0] r);
    int req;
    req = (r == 2'd3) ? 4 : (r == 2'd1) ? 2 : 1;
    return (req > NP) ? NP : req;
  endfunction

  task automatic tick();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  // Releasing P15 (01 then 11) outside a packet advances the selected player.
  task automatic applyStimulus(input logic [1:0] sym, input int hold);
    if (last_sym == 2'b01 && sym == 2'b11 && !busy_m && mlt_m > 1) idx_m = (idx_m + 1) % mlt_m;
    joy_p54  = sym;
    last_sym = sym;
    repeat (hold) tick();
  endtask

  task automatic readCheck(input logic [1:0] sel, input string name);
    applyStimulus(sel, (sel == 2'b11) ? 3 : 2);
    checkOutput(name, joy_din, expNib(sel));
  endtask

  task automatic sendBits(input logic [127:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(data[i] ? 2'b01 : 2'b10, $urandom_range(1, 2));
      applyStimulus(2'b11, $urandom_range(1, 2));
    end
  endtask

  task automatic startPacket();
    applyStimulus(2'b00, 2);
    busy_m = 1'b1;
    checkOutput("nib_00", joy_din, expNib(2'b00));
    checkOutput("busy_set", pkt_busy, 1'b1);
    applyStimulus(2'b11, $urandom_range(1, 2));
  endtask

  task automatic sendPacket(input logic [127:0] data, input bit stopb);
    exp_t e;
    startPacket();
    sendBits(data, 128);
    if (!stopb) begin
      pkt_m = data;
`ifdef SGB_MLT_EN
      if (data[7:3] == 5'h11) begin
        mlt_m = clampReq(data[9:8]);
        idx_m = 0;
      end
`endif
    end
    e.err  = stopb;
    e.data = pkt_m;
    e.mlt  = 3'(mlt_m);
    e.idx  = 2'(idx_m);
    sb.push_back(e);
    applyStimulus(stopb ? 2'b01 : 2'b10, 2);
    busy_m = 1'b0;
    applyStimulus(2'b11, 3);
    checkOutput("busy_clear", pkt_busy, 1'b0);
    checkOutput("mlt_players", mlt_players, 3'(mlt_m));
    checkOutput("player_idx", player_idx, 2'(idx_m));
  endtask

  task automatic doReset();
    joy_p54 = 2'b11;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pkt_m = '0; mlt_m = 1; idx_m = 0; busy_m = 1'b0; last_sym = 2'b11;
    checkOutput("rst_joy_din", joy_din, 4'hF);
    checkOutput("rst_pkt_data", pkt_data, 128'd0);
    checkOutput("rst_busy", pkt_busy, 1'b0);
    checkOutput("rst_mlt", mlt_players, 3'd1);
    checkOutput("rst_idx", player_idx, 2'd0);
  endtask

  function automatic logic [127:0] randData(input bit mlt);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (mlt) d[7:3] = 5'h11;
    return d;
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checkOutput("pulse_exclusive", pkt_valid & pkt_error, 1'b0);
      if (pkt_valid || pkt_error) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse: valid=%0b error=%0b with empty scoreboard", pkt_valid, pkt_error);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", pkt_error, e.err);
          checkOutput("pkt_data", pkt_data, e.data);
          checkOutput("pulse_mlt", mlt_players, e.mlt);
          checkOutput("pulse_idx", player_idx, e.idx);
        end
      end
    end
  end

  initial begin
    logic [127:0] d;
    @(negedge clk);
    doReset();

    joystick = NP * 8'($urandom);
    joystick[7:0] = 8'h05;
    applyStimulus(2'b10, 2);
    checkOutput("dir_latency", joy_din, 4'hA);
    readCheck(2'b01, "btn_read");
    readCheck(2'b11, "id_single");

    for (int i = 0; i < 4; i++) begin
      joystick = {$urandom};
      readCheck(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, "rand_read");
      readCheck(2'b11, "rand_id");
    end

    d = '0;
    d[15:0] = 16'h0389;
    sendPacket(d, 1'b0);
    checkOutput("mlt_pkt_low", pkt_data[15:0], 16'h0389);
    readCheck(2'b11, "id_after_mlt");

    for (int i = 0; i < 4; i++) begin
      joystick = {$urandom};
      readCheck(2'b01, "rot_btn");
      readCheck(2'b11, "rot_id");
      readCheck(2'b10, "rot_dir");
    end

    sendPacket(randData(1'b0), 1'b1);
    readCheck(2'b11, "id_after_err");

    for (int i = 0; i < 4; i++) begin
      joystick = {$urandom};
      sendPacket(randData($urandom_range(0, 1) != 0), $urandom_range(0, 3) == 0);
      readCheck(2'b01, "pkt_loop_btn");
      readCheck(2'b11, "pkt_loop_id");
    end

    startPacket();
    sendBits(randData(1'b0), 60);
    sendPacket(randData(1'b0), 1'b0);

    d = randData(1'b1);
    d[9:8] = 2'd1;
    sendPacket(d, 1'b0);
    readCheck(2'b01, "two_p_btn");
    readCheck(2'b11, "two_p_id");

    startPacket();
    sendBits(randData(1'b0), 30);
    doReset();
    readCheck(2'b11, "id_after_reset");
    sendPacket(randData(1'b0), 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgb_joy_link.md
# sgb_joy_link

Joypad-port link block for the Super Game Boy top level. It sits between the gb core's `joy_p54`/`joy_din` pins and the SNES-side logic, and has three jobs:
- Serve button data for up to four players, with SGB multiplayer ID rotation.
- Deserialise the 128-bit SGB command packets the Game Boy bit-bangs on P14/P15.
- Decode MLT_REQ internally to switch the player count.

All other commands are passed out raw for the SNES-side decoder.

## Interface
Parameters:
- `NUM_PLAYERS`, default 4: supported players, 1/2/4; the MLT_REQ request is clamped to this value.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `clk_en`, input, 1: CPU clock enable; all state advances only when high.
- `joy_p54`, input, 2: select lines from the gb core. Bit 0 = P14, bit 1 = P15, active low.
- `joy_din`, output, 4: joypad nibble to the gb core, active low.
- `joystick`, input, 8*NUM_PLAYERS: per-player buttons, active high. Byte p = {start, select, B, A, down, up, left, right}.
- `pkt_data`, output, 128: last completed packet; byte 0 in bits [7:0], LSB first.
- `pkt_valid`, output, 1: one-clock pulse when `pkt_data` updates.
- `pkt_error`, output, 1: one-clock pulse on a bad stop bit.
- `pkt_busy`, output, 1: high from the reset pulse until the stop bit or an abort.
- `mlt_players`, output, 3: active player count, 1/2/4.
- `player_idx`, output, 2: currently selected player.

## Operation
- `joy_p54` is sampled into a register `p54_q` on each `clk_en`. Edges are detected against the previous sample `p54_qq`.
- `joy_din` is registered on each `clk_en` from `p54_q` and player `player_idx`:
  - `10`: ~{down, up, left, right}.
  - `01`: ~{start, select, B, A}.
  - `00`: ~(dir | btn).
  - `11`: `4'hF - player_idx` when `mlt_players > 1`, otherwise `4'hF`.
- Player rotation: `player_idx` increments when `p54_qq = 01` and `p54_q = 11` (P15 released), and `mlt_players > 1`. It wraps at `mlt_players-1`. It does not increment while `pkt_busy`.
- Packet FSM:
  - IDLE: on `p54_q = 00` → RST, set `pkt_busy`, clear the bit counter and shift register.
  - RST: on `11` → WAIT_BIT.
  - WAIT_BIT: on `10`, shift in 0; on `01`, shift in 1; then → WAIT_HIGH. On `00` → RST (restart, no error).
  - WAIT_HIGH: on `11` → WAIT_BIT if fewer than 128 bits are taken, else → STOP. On `00` → RST. Any other value holds the state; a repeated level does not count as a second bit.
  - STOP: the next bit symbol is the stop bit.
    - Bit `0`: pulse `pkt_valid`, load `pkt_data`, → IDLE.
    - Bit `1`: pulse `pkt_error`, leave `pkt_data` unchanged, → IDLE.
    - `00`: → RST.
- The bit counter is 8 bits wide and runs 0..128. The shift register shifts right, with the new bit entering at bit 127.
- MLT_REQ: a valid packet with `pkt_data[7:3] = 5'h11` sets `mlt_players` from `pkt_data[9:8]`, then clamps to `NUM_PLAYERS`:
  - `0` → 1 player.
  - `1` → 2 players.
  - `2` → 1 player.
  - `3` → 4 players.
  
  `player_idx` resets to 0 on the same cycle.
- Reset values:
  - `joy_din` = `4'hF`; `pkt_data` = 0; `pkt_valid`, `pkt_error`, `pkt_busy` = 0.
  - `mlt_players` = 1; `player_idx` = 0; FSM in IDLE; `p54_q` and `p54_qq` = `2'b11`.
- A reset asserted mid-packet discards the partial packet; no pulse is emitted.

## Timing
- `joy_din` follows `joy_p54` by 2 `clk_en` ticks (input register plus output register).
- `pkt_valid` and `pkt_error` are asserted for exactly one `clk` cycle, in the cycle after the `clk_en` tick that samples the stop bit's symbol. They are never both high.
- `mlt_players` and `player_idx` update in the same cycle as `pkt_valid`.
- Simultaneous rotation edge and MLT_REQ completion: MLT_REQ wins and `player_idx` = 0.
- With `clk_en` low, all registers hold and pulses do not fire.

## Configuration
- `SGB_MLT_EN` defined:
  - Multiplayer logic is present: MLT_REQ decode, `player_idx` rotation, and the ID nibble on `11`.
- `SGB_MLT_EN` undefined:
  - `mlt_players` is tied to 1 and `player_idx` to 0.
  - `11` always returns `4'hF`.
  - Only `joystick[7:0]` is used.
  - Packets are still received and reported.

## Test plan
- Reset, then drive `joy_p54 = 10` with `joystick[7:0] = 8'h05` → `joy_din = 4'hA` two `clk_en` ticks later; `pkt_valid` = 0 throughout.
- Send a reset pulse, 128 bits of MLT_REQ `{8'h89, 8'h03, 14×8'h00}`, then stop bit 0 (`NUM_PLAYERS` = 4) → one `pkt_valid` pulse, `pkt_data[15:0]` = `16'h0389`, `mlt_players` = 4, `player_idx` = 0, `11` reads `4'hF`.
- With 4 players active, cycle `01→11` four times → `11` reads F, E, D, C, then F again (wrap).
- Packet with stop bit 1 → `pkt_error` pulse, `pkt_data` unchanged, FSM back in IDLE.
- Reset pulse (`00`) after 60 bits, followed by a full valid packet → exactly one `pkt_valid` carrying the second packet's data.
- Build without `SGB_MLT_EN` and send MLT_REQ 4-player → `pkt_valid` pulses, `mlt_players` stays 1, `11` reads `4'hF`.
